// File: rtl/cpu_clk_pkg.sv
`default_nettype none
//==============================================================================
// Module   : cpu_clk_pkg
// Brief    : Shared types and constants for the CPU clock-enable controller.
// Revision : 1.0 - initial release
//==============================================================================
package cpu_clk_pkg;

    // Width of the issued-pulse counter
    localparam int CYCLE_W = 32;

    // Controller FSM states; the encoding is visible on the state output
    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_t;

endpackage : cpu_clk_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
//==============================================================================
// Module   : btn_debounce
// Brief    : Two-flop synchronizer followed by a stable-level debouncer.
//            The output follows the synchronized input only after the input
//            has held its new value for DB_CYCLES consecutive clocks.
// Revision : 1.0 - initial release
//==============================================================================
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int                 c_CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DB_CYCLES - 1);

    logic [1:0]         r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dout;
    logic               w_sync;

    assign w_sync = r_sync[1];
    assign dout   = r_dout;

    // Bring the raw input into the clk domain before anything looks at it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], din};
        end
    end

    // Count consecutive cycles at a level different from the accepted one;
    // any return to the accepted level restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_dout <= 1'b0;
        end else if (w_sync != r_dout) begin
            if (r_cnt == c_LAST) begin
                r_dout <= w_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

endmodule : btn_debounce
`default_nettype wire

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : cpu_clk_ctrl
// Brief    : Run / single-step / halt controller producing the CPU clock
//            enable. In RUN a divider issues one cpu_ce every div+1 clocks;
//            a debounced step button issues exactly one pulse from STOP;
//            halt_req locks the controller in HALT until reset.
// Revision : 1.0 - initial release
//==============================================================================
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int DB_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIV_W-1:0]   div,
    input  logic               run_sw,
    input  logic               step_btn,
    input  logic               halt_req,
    output logic               cpu_ce,
    output logic [1:0]         state,
    output logic               halted,
    output logic [CYCLE_W-1:0] cycle_cnt
);

    logic [1:0]         r_run_sync;
    logic               w_run_s;
    logic               w_step_db;
    logic               r_step_q;
    logic               w_step_ev;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [DIV_W-1:0]   w_div_cnt_nxt;
    logic               w_wrap;
    logic               w_run_go;
    logic               w_ce_nxt;
    logic               r_cpu_ce;
    logic [CYCLE_W-1:0] r_cycle_cnt;

    assign w_run_s   = r_run_sync[1];
    assign w_step_ev = w_step_db & ~r_step_q;

    assign cpu_ce    = r_cpu_ce;
    assign state     = r_state;
    assign halted    = (r_state == HALT);
    assign cycle_cnt = r_cycle_cnt;

    // Step button: synchronize and debounce
    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_step_db (
        .clk  (clk),
        .rst  (rst),
        .din  (step_btn),
        .dout (w_step_db)
    );

    // Run switch is a level, so synchronizing is enough; also keep the
    // previous debounced step level for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_sync <= 2'b00;
            r_step_q   <= 1'b0;
        end else begin
            r_run_sync <= {r_run_sync[0], run_sw};
            r_step_q   <= w_step_db;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, divider and pulse decision; halt_req overrides everything
    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = '0;
        w_wrap        = (r_div_cnt >= div);
        w_run_go      = (r_state == RUN) && w_run_s && !halt_req;

        unique case (r_state)
            STOP: begin
                if (w_run_s) begin
                    w_state_nxt = RUN;
                end else if (w_step_ev) begin
                    w_state_nxt = STEP;
                end
            end
            RUN: begin
                if (!w_run_s) begin
                    w_state_nxt = STOP;
                end
            end
            STEP:    w_state_nxt = STOP;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = STOP;
        endcase

        if (halt_req) begin
            w_state_nxt = HALT;
        end

        // Divider holds at zero outside RUN so every RUN entry starts fresh;
        // >= lets a reduced div wrap at once
        if (w_run_go) begin
            w_div_cnt_nxt = w_wrap ? '0 : r_div_cnt + 1'b1;
        end

        w_ce_nxt = !halt_req && ((w_run_go && w_wrap) || (r_state == STEP));
    end

    // Divider, registered enable pulse and pulse counter; the counter
    // updates on the same edge that raises cpu_ce
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt   <= '0;
            r_cpu_ce    <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            r_div_cnt <= w_div_cnt_nxt;
            r_cpu_ce  <= w_ce_nxt;
            if (w_ce_nxt) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
        end
    end

endmodule : cpu_clk_ctrl
`default_nettype wire

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the divide-ratio input.
REQ-002 SHALL have parameter DB_CYCLES, default 1000000, the number of consecutive stable cycles needed to accept a step-button level.
REQ-003 SHALL have port clk, input, 1 bit: board clock; the block's only clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port div, input, DIV_W bits: divide ratio; in RUN, one cpu_ce pulse every div+1 clk cycles.
REQ-006 SHALL have port run_sw, input, 1 bit: raw asynchronous run switch.
REQ-007 SHALL have port step_btn, input, 1 bit: raw asynchronous single-step button.
REQ-008 SHALL have port halt_req, input, 1 bit: synchronous halt request from the CPU (e.g. ecall exit).
REQ-009 SHALL have port cpu_ce, output, 1 bit: registered one-cycle clock-enable pulse consumed by the CPU.
REQ-010 SHALL have port state, output, 2 bits: current FSM state encoding.
REQ-011 SHALL have port halted, output, 1 bit: high while state is HALT.
REQ-012 SHALL have port cycle_cnt, output, 32 bits: count of cpu_ce pulses issued; wraps modulo 2^32.

Function
REQ-013 run_sw and step_btn SHALL each pass through a 2-flop synchronizer before any use.
REQ-014 Synchronized step SHALL be debounced: the debounced level changes only after DB_CYCLES consecutive cycles at the new value.
REQ-015 A step event SHALL be a one-cycle pulse on the 0->1 edge of the debounced step level.
REQ-016 FSM states SHALL be STOP=0, RUN=1, STEP=2 and HALT=3.
REQ-017 Transition STOP->RUN SHALL occur when synchronized run_sw=1.
REQ-018 Transition RUN->STOP SHALL occur when synchronized run_sw=0; the divider clears and no pulse is issued.
REQ-019 Transition STOP->STEP SHALL occur on a step event while run_sw=0; STEP SHALL always go to STOP after one cycle.
REQ-020 Step events in RUN, STEP or HALT SHALL be ignored.
REQ-021 halt_req=1 in any state SHALL force next state HALT, with priority over all other transitions; HALT SHALL be exited only by rst.
REQ-022 Divider counter SHALL count 0..div only in RUN and SHALL be 0 on entry to RUN.
REQ-023 When the divider count is >= div, the count SHALL return to 0 and cpu_ce SHALL be 1 in the next cycle; using >= ensures a reduced div mid-count wraps immediately.
REQ-024 In RUN with div=0, cpu_ce SHALL be high every cycle.
REQ-025 In STEP, cpu_ce SHALL be 1 in the following cycle, giving exactly one pulse per step event.
REQ-026 If halt_req=1 in cycle N, cpu_ce SHALL be 0 from cycle N+1 onward, even if a divider wrap or STEP coincides.
REQ-027 cycle_cnt SHALL increment in the same cycle cpu_ce is high.

Reset
REQ-028 rst SHALL immediately set state to STOP, and cpu_ce, halted, cycle_cnt, the divider count, the synchronizers, the debounce counter and the debounced level all to 0.
REQ-029 Reset asserted mid-RUN or mid-debounce SHALL abort the operation with no trailing cpu_ce pulse.
REQ-030 After rst is released, the first cpu_ce SHALL require a fresh run or step request.

Structure
REQ-031 Package cpu_clk_pkg SHALL hold the state enum type (2 bits) and the constant CYCLE_W=32.
REQ-032 Synchronizer plus debounce SHALL be a sub-module btn_debounce (parameter DB_CYCLES; ports clk, rst, din, dout), instanced for step_btn.
REQ-033 run_sw SHALL use the synchronizer only, without debounce.

Verification (bench overrides DB_CYCLES=4)
REQ-034 run_sw=1, div=3 for 40 cycles -> cpu_ce pulses spaced exactly 4 cycles apart; cycle_cnt=count of pulses (9-10).
REQ-035 run_sw=0, clean step_btn press held 10 cycles -> exactly one cpu_ce pulse, cycle_cnt=1; a 2-cycle glitch -> no pulse.
REQ-036 RUN, div=100, count at 50, then div changed to 10 -> pulse on the next cycle, then every 11 cycles.
REQ-037 RUN, div=0, halt_req pulsed in cycle N -> cpu_ce 0 from N+1, halted=1, state=3; later step and run requests are ignored until rst.
REQ-038 rst asserted while RUN with count mid-way -> state=0, cycle_cnt=0, no cpu_ce; release with run_sw=1 -> first pulse div+1 cycles after RUN entry (plus synchronizer latency).
